// File: rtl/state_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : state_load_sequencer
// Purpose  : Buffers bytes in a FIFO and replays each one as two nibble writes
//            into the downstream nibble-select register, with clear and shadow.
//            Optional macro SEQ_SKIP_EQUAL_EN: skip loads of bytes equal to SHADOW.
// Revision : 1.0  initial release
// ============================================================================
module state_load_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    input  logic [0:7] i_in_data,
    input  logic       i_clr_req,
    output logic       o_select,
    output logic [0:7] o_data_out,
    output logic       o_state_clr,
    output logic [0:7] o_shadow,
    output logic       o_busy,
    output logic       o_done
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_HI = 2'd1,
        S_LOAD_LO = 2'd2,
        S_CLEAR   = 2'd3
    } state_t;

    state_t          r_state;
    logic [0:7]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_in_ready;
    logic            r_clr_pend;
    logic [0:7]      r_byte;
    logic            r_select;
    logic [0:7]      r_data_out;
    logic            r_state_clr;
    logic [0:7]      r_shadow;
    logic            r_done;

    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_decide;
    logic            w_go_clear;
    logic            w_go_load;
    logic            w_skip;
    logic [0:7]      w_head;
    logic [CW-1:0]   w_count_nxt;

    assign w_push  = i_in_valid && r_in_ready;
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // IDLE, LOAD_LO and CLEAR share the same exit decision; LOAD_HI never branches.
    assign w_decide   = (r_state != S_LOAD_HI);
    assign w_go_clear = w_decide && r_clr_pend;

`ifdef SEQ_SKIP_EQUAL_EN
    assign w_skip = w_decide && !r_clr_pend && !w_empty && (w_head == r_shadow);
`else
    assign w_skip = 1'b0;
`endif

    assign w_go_load   = w_decide && !r_clr_pend && !w_empty && !w_skip;
    assign w_pop       = w_go_load || w_skip;
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_clr_pend  <= 1'b0;
            r_byte      <= '0;
            r_select    <= 1'b1;
            r_data_out  <= '0;
            r_state_clr <= 1'b1;
            r_shadow    <= '0;
            r_done      <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            // Ready follows the registered count, so a pop while full frees a slot one cycle later.
            r_in_ready <= (w_count_nxt != C_FULL);
            r_clr_pend <= w_go_clear ? 1'b0 : (r_clr_pend | i_clr_req);

            r_done      <= 1'b0;
            r_state_clr <= 1'b0;
            r_select    <= 1'b1;
            if (w_go_clear) begin
                r_state     <= S_CLEAR;
                r_state_clr <= 1'b1;
                r_data_out  <= '0;
                r_shadow    <= '0;
            end else if (w_go_load) begin
                r_state         <= S_LOAD_HI;
                r_byte          <= w_head;
                r_data_out      <= {w_head[0:3], r_shadow[4:7]};
                r_shadow[0:3]   <= w_head[0:3];
            end else if (r_state == S_LOAD_HI) begin
                r_state         <= S_LOAD_LO;
                r_select        <= 1'b0;
                r_data_out      <= r_byte;
                r_shadow[4:7]   <= r_byte[4:7];
                r_done          <= 1'b1;
            end else begin
                // Idle refresh rewrites the upper nibble with its current value.
                r_state    <= S_IDLE;
                r_data_out <= r_shadow;
                r_done     <= w_skip;
            end
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_select    = r_select;
    assign o_data_out  = r_data_out;
    assign o_state_clr = r_state_clr;
    assign o_shadow    = r_shadow;
    assign o_done      = r_done;
    assign o_busy      = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: doc/state_load_sequencer.md
# state_load_sequencer

Upstream sequencer for the nibble-select state register stage. It accepts bytes on a valid/ready input and buffers them in a small FIFO. It replays each byte as two clocked nibble writes: SELECT=1 loads the upper nibble, SELECT=0 loads the lower. It also drives the downstream register's active-high clear and keeps a shadow copy of the register contents. The downstream stage loads on every CLOCK edge, so this block holds its outputs at refresh values whenever it is idle.

## Interface
- DEPTH, 4, FIFO depth in bytes; power of 2, minimum 2.
- CLOCK  in  1  single clock; all state changes on posedge.
- RST  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  upstream byte valid.
- IN_READY  out  1  block can accept a byte; equals !full, and is 0 while RST is low.
- IN_DATA  in  [0:7]  byte to load; bit 0 is the MSB.
- CLR_REQ  in  1  single-cycle request to clear the downstream register.
- SELECT  out  1  to downstream SELECT; 1 writes [0:3], 0 writes [4:7].
- DATA_OUT  out  [0:7]  to downstream DATA_IN.
- STATE_CLR  out  1  to downstream clear input, active-high.
- SHADOW  out  [0:7]  value the downstream register holds after the current cycle's edge.
- BUSY  out  1  FSM not in IDLE, or FIFO not empty.
- DONE  out  1  one-cycle pulse when a byte load completes.

## Operation
- FIFO:
  - Push when IN_VALID && IN_READY.
  - Pop when the FSM enters LOAD_HI.
  - Simultaneous push and pop is legal, and occupancy stays unchanged.
  - Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.
- FSM states are IDLE, LOAD_HI, LOAD_LO and CLEAR. Registered outputs per state:
  - IDLE: SELECT=1, DATA_OUT=SHADOW, STATE_CLR=0. This rewrites the same upper nibble, so the downstream contents stay unchanged.
  - LOAD_HI: SELECT=1, DATA_OUT={byte[0:3], SHADOW[4:7]}. SHADOW[0:3] takes byte[0:3].
  - LOAD_LO: SELECT=0, DATA_OUT=byte. SHADOW[4:7] takes byte[4:7]. DONE=1.
  - CLEAR: STATE_CLR=1, SELECT=1, DATA_OUT=0. SHADOW takes 0. Lasts exactly one cycle.
- Transitions:
  - From IDLE: go to CLEAR if a clear is pending; otherwise go to LOAD_HI if the FIFO is non-empty; otherwise stay in IDLE.
  - LOAD_HI always goes to LOAD_LO. A byte is never split by a clear.
  - From LOAD_LO: go to CLEAR if a clear is pending; otherwise go to LOAD_HI if the FIFO is non-empty (back-to-back); otherwise go to IDLE.
  - CLEAR uses the same exits as LOAD_LO.
- CLR_REQ sets a sticky pending flag that CLEAR consumes. Repeated requests before service merge into one clear.
- A clear never flushes the FIFO. Bytes queued before a clear are loaded after it.

## Timing
- Reset values (while RST is low):
  - FSM=IDLE, FIFO empty.
  - SELECT=1, DATA_OUT=0, SHADOW=0.
  - STATE_CLR=1, holding the downstream register clear throughout reset.
  - BUSY=0, DONE=0, IN_READY=0, clear-pending=0.
- First edge after RST rises: STATE_CLR goes to 0 and IN_READY goes to 1.
- Byte accepted at edge t into an empty FIFO with the FSM idle:
  - LOAD_HI is driven in cycle t+1.
  - Downstream [0:3] is updated at edge t+2.
  - LOAD_LO plus DONE are driven in cycle t+2.
  - Downstream [4:7] is updated at edge t+3.
- Sustained throughput is one byte per 2 cycles, so a continuous source sees the FIFO fill and IN_READY drop.
- Full FIFO: IN_READY=0, so no push occurs. A pop in the same cycle does not raise IN_READY until the next cycle, because IN_READY is derived from the registered count.
- Reset asserted mid-load: all state returns to reset values immediately. The partially written byte is lost, and STATE_CLR=1 clears the downstream register.

## Configuration
- SEQ_SKIP_EQUAL_EN defined: a popped byte equal to SHADOW skips both load cycles. The FSM stays in (or enters) IDLE, DONE pulses for one cycle in the pop cycle, and throughput for that byte is 1 cycle.
- Not defined: every byte takes LOAD_HI then LOAD_LO, regardless of its value.

## Test plan
- Reset release, no traffic -> STATE_CLR=1 during reset and 0 after the first edge; SELECT=1 and DATA_OUT=0x00 held; downstream stays 0x00.
- Single byte 0xA5 at edge t -> cycle t+1: SELECT=1, DATA_OUT=0xA0; cycle t+2: SELECT=0, DATA_OUT=0xA5, DONE=1; SHADOW=0xA5; then IDLE refresh with DATA_OUT=0xA5.
- Burst 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 with IN_VALID held high and DEPTH=4 -> IN_READY drops when the FIFO is full; loads are back-to-back with no IDLE gap; six DONE pulses, each 2 cycles apart; final SHADOW=0x66.
- CLR_REQ pulsed during the LOAD_HI of 0x3C, with 0x77 queued -> 0x3C completes, then CLEAR (STATE_CLR=1, SHADOW=0x00), then 0x77 loads.
- RST pulled low in the LOAD_LO of 0xF0 -> all outputs take reset values asynchronously; after release, downstream=0x00 and the FIFO is empty.
- With SEQ_SKIP_EQUAL_EN, send 0x5A twice -> first byte takes 2 load cycles; second produces only a one-cycle DONE with SELECT held at 1.
